// File: rtl/alu54b_addsub_wrapper.sv
// Two-stage clocked 36-bit add/subtract built around a 54-bit ALU slice.
// Operands are zero-extended, and the 55-bit two's-complement result cannot overflow.
module alu54b_addsub_wrapper #(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned ALU_W = 54,
    parameter int unsigned OUT_W = ALU_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             addsub,
    input  logic             ce,
    output logic [OUT_W-1:0] c
);

    logic [IN_W-1:0]  a_q;
    logic [IN_W-1:0]  b_q;
    logic             op_q;
    logic [OUT_W-1:0] c_q;

    logic [ALU_W-1:0] a_alu;
    logic [ALU_W-1:0] b_alu;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] b_opnd;
    logic [OUT_W-1:0] cin;
    logic [OUT_W-1:0] alu_res;

    // Subtract is done as a + ~b + 1. The inversion covers the full 55 bits,
    // so a negative difference carries its sign into bit 54.
    always_comb begin
        a_alu   = ALU_W'(a_q);
        b_alu   = ALU_W'(b_q);
        a_ext   = {1'b0, a_alu};
        b_ext   = {1'b0, b_alu};
        b_opnd  = op_q ? b_ext : ~b_ext;
        cin     = {{(OUT_W-1){1'b0}}, ~op_q};
        alu_res = a_ext + b_opnd + cin;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= 1'b0;
            c_q  <= '0;
        end else if (ce) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= addsub;
            c_q  <= alu_res;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_alu54b_addsub_wrapper.sv
// Self-checking bench for alu54b_addsub_wrapper.
// It uses directed vectors, stall, reset and op-switch sequences, and random traffic checked against a model.
module tb_alu54b_addsub_wrapper;

    localparam logic [35:0] MAX36 = 36'hF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic [35:0] a;
    logic [35:0] b;
    logic        addsub;
    logic        ce;
    logic [54:0] c;

    int n_tests;
    int n_fail;

    // Reference state: value expected on c, and the result of the pair sampled last.
    logic [54:0] m_c;
    logic [54:0] m_next;

    alu54b_addsub_wrapper dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .addsub (addsub),
        .ce     (ce),
        .c      (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [54:0] ref_f(input logic [35:0] x, input logic [35:0] y,
                                          input logic op);
        longint s;
        s = op ? (longint'(x) + longint'(y)) : (longint'(x) - longint'(y));
        return s[54:0];
    endfunction

    task automatic step(input logic [35:0] ta, input logic [35:0] tb_v, input logic top,
                        input logic tce, input logic trst);
        a      = ta;
        b      = tb_v;
        addsub = top;
        ce     = tce;
        rst    = trst;
        @(posedge clk);
        #1;
        if (!trst) begin
            m_c    = '0;
            m_next = '0;
        end else if (tce) begin
            m_c    = m_next;
            m_next = ref_f(ta, tb_v, top);
        end
    endtask

    task automatic check(input string name, input logic [54:0] exp);
        n_tests++;
        if (c !== exp) begin
            n_fail++;
            $display("FAIL %s: c=%h expected %h", name, c, exp);
        end
    endtask

    typedef struct {
        logic [35:0] va;
        logic [35:0] vb;
        logic        vop;
        logic [54:0] vexp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] r64;
        logic [35:0] ra;
        logic [35:0] rb;
        logic        rop;
        logic        rce;
        logic        rrst;

        n_tests = 0;
        n_fail  = 0;
        m_c     = '0;
        m_next  = '0;

        vecs[0] = '{36'd1, 36'd2, 1'b1, 55'd3};
        vecs[1] = '{36'd2, 36'd3, 1'b1, 55'd5};
        vecs[2] = '{MAX36, MAX36, 1'b1, 55'h1F_FFFF_FFFE};
        vecs[3] = '{36'd2, 36'd3, 1'b0, 55'h7F_FFFF_FFFF_FFFF};
        vecs[4] = '{MAX36, 36'd1, 1'b0, 55'hF_FFFF_FFFE};
        vecs[5] = '{36'd4, MAX36, 1'b0, 55'h7F_FFF0_0000_0005};

        // Reset is held with arbitrary inputs and ce toggling; c must stay 0.
        for (int i = 0; i < 10; i++) begin
            r64 = {$urandom(), $urandom()};
            step(r64[35:0], r64[63:28], r64[0], r64[1] | (i < 5), 1'b0);
            check("reset_hold", 55'd0);
        end

        // Directed table, streamed back to back. Each result appears one edge later.
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].va, vecs[i].vb, vecs[i].vop, 1'b1, 1'b1);
            if (i == 0) check("post_reset_zero", 55'd0);
            else        check("table", vecs[i-1].vexp);
        end
        step(36'd0, 36'd0, 1'b1, 1'b1, 1'b1);
        check("table_last", vecs[5].vexp);

        // The stall cycle must neither duplicate nor drop a result.
        step(36'd1, 36'd2, 1'b1, 1'b1, 1'b1);
        check("stall_pre", 55'd0);
        step(36'd2, 36'd3, 1'b1, 1'b0, 1'b1);
        check("stall_hold", 55'd0);
        step(36'd2, 36'd3, 1'b1, 1'b1, 1'b1);
        check("stall_first", 55'd3);
        step(36'd9, 36'd9, 1'b1, 1'b1, 1'b1);
        check("stall_second", 55'd5);
        step(36'd0, 36'd0, 1'b1, 1'b1, 1'b1);
        check("stall_third", 55'd18);

        // addsub toggles for each operand pair.
        step(36'd7, 36'd5, 1'b0, 1'b1, 1'b1);
        step(36'd7, 36'd5, 1'b1, 1'b1, 1'b1);
        check("op_sw0", 55'd2);
        step(36'd5, 36'd7, 1'b0, 1'b1, 1'b1);
        check("op_sw1", 55'd12);
        step(36'd5, 36'd7, 1'b1, 1'b1, 1'b1);
        check("op_sw2", 55'h7F_FFFF_FFFF_FFFE);
        step(36'd1, 36'd1, 1'b1, 1'b1, 1'b0);
        check("mid_reset", 55'd0);
        step(36'd3, 36'd4, 1'b1, 1'b1, 1'b1);
        check("mid_reset_flush", 55'd0);
        step(36'd0, 36'd0, 1'b1, 1'b1, 1'b1);
        check("mid_reset_resume", 55'd7);

        // Random traffic compared with the arithmetic model.
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom(), $urandom()};
            ra  = r64[35:0];
            r64 = {$urandom(), $urandom()};
            rb  = r64[35:0];
            case ($urandom_range(7, 0))
                0: ra = MAX36;
                1: rb = MAX36;
                2: ra = '0;
                3: rb = '0;
                default: ;
            endcase
            rop  = 1'($urandom_range(1, 0));
            rce  = ($urandom_range(3, 0) != 0);
            rrst = ($urandom_range(31, 0) != 0);
            step(ra, rb, rop, rce, rrst);
            check("random", m_c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
